// File: rtl/sram_mem_ctrl.sv
// Word-wide load/store controller for a 16-bit asynchronous SRAM.
// Each access runs a LOW halfword phase then a HIGH halfword phase of HOLD cycles each.
module sram_mem_ctrl #(
    parameter int HOLD      = 2,
    parameter int BASE_ADDR = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [15:0] rd_lo_q, rd_lo_d;
    logic [31:0] read_data_q, read_data_d;

    logic [31:0] offset;
    logic        req;
    logic        phase_last;
    logic        unused_offset_bits;

    // Only offset[18:2] selects the SRAM word; upper bits wrap and byte lanes are ignored.
    assign offset             = ALU_result - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign req                = MEM_R_EN | MEM_W_EN;
    assign phase_last         = (cnt_q == LAST);
    assign read_data          = read_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = LOW;
            LOW:     if (phase_last) state_d = HIGH;
            HIGH:    if (phase_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on every phase entry; read halves are latched on each phase's last cycle.
    always_comb begin
        cnt_d       = 4'd0;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_d        = wr_q;
        rd_lo_d     = rd_lo_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = offset[18:2];
                    data_d = Val_Rm;
                    wr_d   = MEM_W_EN;
                end
            end
            LOW: begin
                cnt_d = phase_last ? 4'd0 : cnt_q + 4'd1;
                if (phase_last && !wr_q) rd_lo_d = SRAM_DQ_in;
            end
            HIGH: begin
                cnt_d = phase_last ? 4'd0 : cnt_q + 4'd1;
                if (phase_last && !wr_q) read_data_d = {SRAM_DQ_in, rd_lo_q};
            end
            default: cnt_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 4'd0;
            addr_q      <= 17'd0;
            data_q      <= 32'd0;
            wr_q        <= 1'b0;
            rd_lo_q     <= 16'd0;
            read_data_q <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            rd_lo_q     <= rd_lo_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        ready       = 1'b0;
        SRAM_ADDR   = 18'd0;
        SRAM_DQ_out = 16'd0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;
        case (state_q)
            IDLE: ready = ~req;
            LOW: begin
                SRAM_ADDR = {addr_q, 1'b0};
                if (wr_q) begin
                    SRAM_WE_N   = 1'b0;
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_DQ_out = data_q[15:0];
                end
            end
            HIGH: begin
                SRAM_ADDR = {addr_q, 1'b1};
                if (wr_q) begin
                    SRAM_WE_N   = 1'b0;
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_DQ_out = data_q[31:16];
                end
            end
            default: ready = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomised bench for sram_mem_ctrl: an access-level model predicts every output each cycle,
// with directed sequences pinning literal values for stores, loads, wrap-around and reset abort.
module tb_sram_mem_ctrl;

    localparam int HOLD = 2;
    localparam int BASE = 1024;

    logic        clk;
    logic        rst;
    logic        memREn;
    logic        memWEn;
    logic [31:0] aluResult;
    logic [31:0] valRm;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sramAddr;
    logic [15:0] sramDqOut;
    logic [15:0] sramDqIn;
    logic        sramDqOe;
    logic        sramWeN;

    int compared   = 0;
    int mismatched = 0;

    sram_mem_ctrl #(.HOLD(HOLD), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (memREn),
        .MEM_W_EN   (memWEn),
        .ALU_result (aluResult),
        .Val_Rm     (valRm),
        .read_data  (readData),
        .ready      (ready),
        .SRAM_ADDR  (sramAddr),
        .SRAM_DQ_out(sramDqOut),
        .SRAM_DQ_in (sramDqIn),
        .SRAM_DQ_oe (sramDqOe),
        .SRAM_WE_N  (sramWeN)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Device memory is written from the DUT pins; reference memory from completed model accesses.
    logic [15:0] devMem [int];
    logic [15:0] refMem [int];

    // Access model: k counts cycles since the accepting IDLE cycle (k=0 is that cycle).
    bit          mBusy;
    int          mK;
    int          mWord;
    logic [31:0] mData;
    bit          mWr;
    logic [31:0] mRead;

    function automatic logic [15:0] initVal(int a);
        return 16'((a * 40503 + 12345) & 16'hFFFF);
    endfunction

    function logic [15:0] devRead(int a);
        return devMem.exists(a) ? devMem[a] : initVal(a);
    endfunction

    function logic [15:0] refRead(int a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    function automatic int wordOf(logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'(BASE)) & 32'h0007_FFFF;
        return int'(off >> 2);
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBusy = 0;
        mK    = 0;
        mRead = 32'd0;
    endtask

    task automatic applyStimulus(logic rs, logic r, logic w, logic [31:0] a, logic [31:0] d);
        rst       = rs;
        memREn    = r;
        memWEn    = w;
        aluResult = a;
        valRm     = d;
    endtask

    task automatic checkOutput();
        logic        expReady;
        logic [17:0] expAddr;
        logic [15:0] expDq;
        logic        expOe;
        logic        expWeN;
        bit          checkDq;
        expReady = 1'b0;
        expAddr  = 18'd0;
        expDq    = 16'd0;
        expOe    = 1'b0;
        expWeN   = 1'b1;
        checkDq  = 1;
        if (!mBusy) begin
            expReady = !(memREn || memWEn);
        end else if (mK <= HOLD || mK <= 2 * HOLD) begin
            bit hi;
            hi      = (mK > HOLD);
            expAddr = 18'(mWord * 2 + (hi ? 1 : 0));
            if (mWr) begin
                expWeN = 1'b0;
                expOe  = 1'b1;
                expDq  = hi ? mData[31:16] : mData[15:0];
            end else begin
                checkDq = 0;
            end
        end else begin
            expReady = 1'b1;
        end
        checkVal("ready", 32'(ready), 32'(expReady));
        checkVal("sram_addr", 32'(sramAddr), 32'(expAddr));
        checkVal("we_n", 32'(sramWeN), 32'(expWeN));
        checkVal("dq_oe", 32'(sramDqOe), 32'(expOe));
        if (checkDq) checkVal("dq_out", 32'(sramDqOut), 32'(expDq));
        checkVal("read_data", readData, mRead);
    endtask

    task automatic modelAdvance();
        if (rst) begin
            modelReset();
        end else if (!mBusy) begin
            if (memREn || memWEn) begin
                mBusy = 1;
                mK    = 1;
                mWord = wordOf(aluResult);
                mData = valRm;
                mWr   = memWEn;
            end
        end else if (mK == 2 * HOLD) begin
            if (mWr) begin
                refMem[mWord * 2]     = mData[15:0];
                refMem[mWord * 2 + 1] = mData[31:16];
            end else begin
                mRead = {refRead(mWord * 2 + 1), refRead(mWord * 2)};
            end
            mK++;
        end else if (mK == 2 * HOLD + 1) begin
            mBusy = 0;
        end else begin
            mK++;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, let the SRAM react, then compare.
    task automatic runCycle(logic rs, logic r, logic w, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        applyStimulus(rs, r, w, a, d);
        if (rs) modelReset();
        #1;
        if (sramWeN === 1'b0) devMem[int'(sramAddr)] = sramDqOut;
        sramDqIn = devRead(int'(sramAddr));
        #1;
        checkOutput();
        modelAdvance();
    endtask

    logic [17:0] litAddr [6];
    logic [15:0] litDq   [6];
    logic        litWeN  [6];
    logic        litReady[6];
    logic        curR;
    logic        curW;

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        sramDqIn = 16'd0;
        modelReset();
        #2;
        checkVal("reset_read_data", readData, 32'd0);
        checkVal("reset_we_n", 32'(sramWeN), 32'd1);
        runCycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        runCycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Store 0xDEADBEEF at byte 1028 (word 1): literal pin/strobe sequence.
        litAddr  = '{18'd0, 18'd2, 18'd2, 18'd3, 18'd3, 18'd0};
        litDq    = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
        litWeN   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        litReady = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            runCycle(1'b0, 1'b0, i == 0, 32'd1028, 32'hDEAD_BEEF);
            checkVal("lit_store_addr", 32'(sramAddr), 32'(litAddr[i]));
            checkVal("lit_store_dq", 32'(sramDqOut), 32'(litDq[i]));
            checkVal("lit_store_we_n", 32'(sramWeN), 32'(litWeN[i]));
            checkVal("lit_store_ready", 32'(ready), 32'(litReady[i]));
        end

        // Load it back.
        for (int i = 0; i < 6; i++) begin
            runCycle(1'b0, i == 0, 1'b0, 32'd1028, 32'h0);
            checkVal("lit_load_we_n", 32'(sramWeN), 32'd1);
        end
        checkVal("lit_load_data", readData, 32'hDEAD_BEEF);

        // Simultaneous read and write requests behave as a write to word 0.
        litAddr = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd1, 18'd0};
        for (int i = 0; i < 6; i++) begin
            runCycle(1'b0, i == 0, i == 0, 32'd1024, 32'h1234_5678);
            checkVal("lit_rw_addr", 32'(sramAddr), 32'(litAddr[i]));
            checkVal("lit_rw_we_n", 32'(sramWeN), 32'(litWeN[i]));
        end
        checkVal("lit_rw_keeps_data", readData, 32'hDEAD_BEEF);

        // Misaligned address and wrap-around below BASE.
        for (int i = 0; i < 6; i++) begin
            runCycle(1'b0, i == 0, 1'b0, 32'd1026, 32'h0);
            if (i == 1) checkVal("lit_misaligned_addr", 32'(sramAddr), 32'd0);
        end
        checkVal("lit_misaligned_data", readData, 32'h1234_5678);
        for (int i = 0; i < 6; i++) begin
            runCycle(1'b0, i == 0, 1'b0, 32'd0, 32'h0);
            if (i == 1) checkVal("lit_wrap_lo", 32'(sramAddr), 32'h3FE00);
            if (i == 3) checkVal("lit_wrap_hi", 32'(sramAddr), 32'h3FE01);
        end

        // Reset on the second HIGH cycle of a write to word 100, then a normal load.
        runCycle(1'b0, 1'b0, 1'b1, 32'd1424, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        runCycle(1'b1, 1'b0, 1'b1, 32'd1424, 32'hCAFE_F00D);
        checkVal("lit_abort_we_n", 32'(sramWeN), 32'd1);
        checkVal("lit_abort_oe", 32'(sramDqOe), 32'd0);
        checkVal("lit_abort_read_data", readData, 32'd0);
        runCycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 7; i++) runCycle(1'b0, i == 0, 1'b0, 32'd1028, 32'h0);
        checkVal("lit_after_abort_load", readData, 32'hDEAD_BEEF);

        // Back-to-back loads with the request held: ready low 5 cycles, high 1, twice over.
        for (int i = 0; i < 12; i++) begin
            runCycle(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0);
            checkVal("lit_b2b_ready", 32'(ready), 32'((i % 6) == 5));
        end
        runCycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Random traffic over a small window of words, with inputs changing mid-access.
        curR = 1'b0;
        curW = 1'b0;
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            if ($urandom_range(3) != 0) begin
                curR = ($urandom_range(2) == 0);
                curW = ($urandom_range(2) == 0);
            end
            a = ($urandom_range(15) == 0) ? 32'($urandom_range(3))
                                          : 32'(BASE + $urandom_range(7) * 4 + $urandom_range(3));
            runCycle(1'b0, curR, curW, a, $urandom);
        end
        for (int i = 0; i < 8; i++) runCycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
